rgb_breath_sequencer: RTL and testbench
=======================================

Name: rgb_breath_sequencer

Overview:
- Upstream pattern source for the RGB LED driver stage. Generates the `red_en`, `green_en` and `blue_en` enables that the driver consumes.
- Replaces the plain divider-decoded on/off pattern with a PWM "breathing" sequence.
- Lights one colour at a time: fade in, fade out, then advance R -> G -> B -> R.
- Runs from the internal 48 MHz oscillator clock.

Parameters:
- PWM_BITS, 8, width of PWM counter and brightness level; MAX = 2^PWM_BITS-1.
- STEP_DIV, 187500, clk cycles per brightness step (~3.9 ms at 48 MHz; ~2 s per colour at defaults); must be >= 2.

Ports:
- clk  input  1  system clock (internal oscillator output).
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  1 = sequence advances; 0 = pause, outputs dark.
- red_en  output  1  red channel enable to LED driver, registered.
- green_en  output  1  green channel enable, registered.
- blue_en  output  1  blue channel enable, registered.
- color  output  2  current colour: 0 = red, 1 = green, 2 = blue (3 never occurs).
- cycle_done  output  1  one-clk pulse when blue finishes its fade-out.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all outputs 0; state = IDLE; color = 0.
  - level = 0, duty_q = 0, pwm_cnt = 0, pre_cnt = 0.
- Counters (advance only while run = 1):
  - pwm_cnt: PWM_BITS wide, +1 per clk, wraps MAX -> 0.
  - pre_cnt: counts 0..STEP_DIV-1, wraps to 0.
  - tick = run & (pre_cnt == STEP_DIV-1).
- FSM states: IDLE, FADE_IN, FADE_OUT.
  - IDLE: on first clk with run = 1 -> FADE_IN, level = 0, color = 0. Counters start counting that same clk.
  - FADE_IN, tick, level < MAX: level +1.
  - FADE_IN, tick, level == MAX: -> FADE_OUT, level unchanged.
  - FADE_OUT, tick, level > 0: level -1.
  - FADE_OUT, tick, level == 0: -> FADE_IN; color advances 0 -> 1 -> 2 -> 0. If color was 2, cycle_done = 1 for exactly that one clk.
  - No tick: state, level and color hold.
- Ticks per colour: 2*(MAX+1), i.e. 2*(MAX+1)*STEP_DIV clk.
- Duty latching:
  - duty_q <= level, only on clks where run = 1 and pwm_cnt == MAX (period boundary).
  - A level change therefore takes effect at the start of the next PWM period; no mid-period glitch.
- Output registers, 1 clk latency from the pwm_cnt / duty_q / color values:
  - red_en <= run & (color == 0) & (pwm_cnt < duty_q); same for green (color == 1) and blue (color == 2).
  - At most one enable is high at any time.
  - duty_q = 0 -> channel fully off. duty_q = MAX -> on for MAX of MAX+1 cycles per period.
- Pause (run = 0):
  - all counters, level, duty_q, state and color freeze.
  - enables go 0 on the next clk; cycle_done = 0.
  - When run returns to 1, the sequence resumes from the frozen values. It does not restart.
- Reset mid-sequence: immediate return to reset values; restart requires run = 1 again (via IDLE).
- Arithmetic: level never overflows or underflows, because the FSM guards both MAX and 0. pre_cnt compare is exact equality.

Test Plan (PWM_BITS=4, STEP_DIV=4 unless noted):
1. Reset: hold rst_n = 0 with run = 1 -> all enables 0, color = 0, cycle_done = 0. Release rst_n -> first enable pulse on red_en only.
2. Full breath: run = 1 for 128 clk -> red only; level ramps 0..15..0; color becomes 1 exactly 128 clk after leaving IDLE. Green then blue, each 128 clk. cycle_done pulses once, 384 clk after start; color then 0.
3. Duty check: force level = 5 via a FADE_IN ramp, observe one full PWM period after the latch boundary -> red_en high exactly 5 of 16 clk. At level 15 -> high 15 of 16.
4. Pause: drop run at clk 50 for 100 clk -> enables 0 from the next clk; color, level and pre_cnt unchanged. Restore run -> color change occurs at clk 228 (128 + 100), not 128.
5. Mid-run reset: assert rst_n = 0 asynchronously mid-FADE_OUT on green -> outputs 0 without a clk edge. After release -> sequence restarts at red, level 0.
6. Exclusivity: random run toggling for 10,000 clk -> never more than one enable high; color never 3; cycle_done never high for 2 consecutive clk.

Source files
------------

// File: rtl/rgb_breath_sequencer.sv
// PWM breathing pattern source for the RGB LED driver.
// One colour at a time fades in and out, then hands over R -> G -> B -> R.
module rgb_breath_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 187500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       red_en,
  output logic       green_en,
  output logic       blue_en,
  output logic [1:0] color,
  output logic       cycle_done
);

  localparam int PRE_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    FADE_IN,
    FADE_OUT
  } state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [1:0]          color_q, color_d;
  logic                red_en_q, red_en_d;
  logic                green_en_q, green_en_d;
  logic                blue_en_q, blue_en_d;
  logic                cycle_done_q, cycle_done_d;
  logic                tick;
  logic                lit;

  assign tick = run & (pre_cnt_q == PRE_LAST);

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    pre_cnt_d = pre_cnt_q;
    duty_d    = duty_q;
    if (run) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      pre_cnt_d = (pre_cnt_q == PRE_LAST)
                ? '0 : pre_cnt_q + 1'b1;
      // Latch only at the period boundary so a
      // running period never changes mid-way.
      if (pwm_cnt_q == MAX) duty_d = level_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    color_d      = color_q;
    cycle_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FADE_IN;
          level_d = '0;
          color_d = 2'd0;
        end
      end
      FADE_IN: begin
        if (tick) begin
          if (level_q == MAX) state_d = FADE_OUT;
          else level_d = level_q + 1'b1;
        end
      end
      FADE_OUT: begin
        if (tick) begin
          if (level_q == '0) begin
            state_d      = FADE_IN;
            color_d      = (color_q == 2'd2)
                         ? 2'd0 : color_q + 2'd1;
            cycle_done_d = (color_q == 2'd2);
          end else begin
            level_d = level_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lit = run & (pwm_cnt_q < duty_q);

  always_comb begin
    red_en_d   = 1'b0;
    green_en_d = 1'b0;
    blue_en_d  = 1'b0;
    unique case (1'b1)
      (color_q == 2'd0): red_en_d   = lit;
      (color_q == 2'd1): green_en_d = lit;
      (color_q == 2'd2): blue_en_d  = lit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      level_q      <= '0;
      duty_q       <= '0;
      pwm_cnt_q    <= '0;
      pre_cnt_q    <= '0;
      color_q      <= 2'd0;
      red_en_q     <= 1'b0;
      green_en_q   <= 1'b0;
      blue_en_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      duty_q       <= duty_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      color_q      <= color_d;
      red_en_q     <= red_en_d;
      green_en_q   <= green_en_d;
      blue_en_q    <= blue_en_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign red_en     = red_en_q;
  assign green_en   = green_en_q;
  assign blue_en    = blue_en_q;
  assign color      = color_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_rgb_breath_sequencer.sv
// Bench for rgb_breath_sequencer against an arithmetic model
// indexed by the number of run cycles since the sequence started.
module tb_rgb_breath_sequencer;

  localparam int PB = 4;
  localparam int SD = 4;
  localparam int PER = 1 << PB;
  localparam int MX = PER - 1;
  localparam int P = 2 * PER;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       red_en, green_en, blue_en;
  logic [1:0] color;
  logic       cycle_done;

  int n;
  int passed;
  int failed;
  int total;
  int cd_count;
  logic prev_cd;

  rgb_breath_sequencer #(
    .PWM_BITS(PB),
    .STEP_DIV(SD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .red_en    (red_en),
    .green_en  (green_en),
    .blue_en   (blue_en),
    .color     (color),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  // k = run cycles since start; ticks so far = k / SD
  function automatic int lvl(input int k);
    int p;
    p = (k / SD) % P;
    return (p < PER) ? p : (P - 1 - p);
  endfunction

  function automatic int col(input int k);
    return ((k / SD) / P) % 3;
  endfunction

  function automatic int duty(input int k);
    int m;
    m = (k / PER) * PER;
    return (m == 0) ? 0 : lvl(m - 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, "_red"}, 32'(red_en), 0);
    chk({tag, "_green"}, 32'(green_en), 0);
    chk({tag, "_blue"}, 32'(blue_en), 0);
    chk({tag, "_color"}, 32'(color), 0);
    chk({tag, "_done"}, 32'(cycle_done), 0);
  endtask

  task automatic model_reset();
    n = 0;
    prev_cd = 1'b0;
    cd_count = 0;
  endtask

  task automatic step(input logic r);
    int b;
    int er, eg, eb, ecd;
    run = r;
    @(posedge clk);
    #1;
    er = 0; eg = 0; eb = 0; ecd = 0;
    if (r) begin
      b = n;
      n++;
      if ((b % PER) < duty(b)) begin
        er = int'(col(b) == 0);
        eg = int'(col(b) == 1);
        eb = int'(col(b) == 2);
      end
      ecd = int'((n % SD == 0) && ((n / SD) % (3 * P) == 0));
    end
    chk("red_en", 32'(red_en), er);
    chk("green_en", 32'(green_en), eg);
    chk("blue_en", 32'(blue_en), eb);
    chk("color", 32'(color), col(n));
    chk("cycle_done", 32'(cycle_done), ecd);
    chk("onehot", 32'($onehot0({red_en, green_en, blue_en})), 1);
    chk("done_pair", 32'(prev_cd & cycle_done), 0);
    if (cycle_done) cd_count++;
    prev_cd = cycle_done;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total = 0;
    model_reset();

    // reset held with run high
    rst_n = 1'b0;
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_dark("reset");
    rst_n = 1'b1;

    // one full R/G/B cycle and a bit more
    for (int i = 0; i < 400; i++) step(1'b1);
    chk("cd_count", 32'(cd_count), 1);

    // pause at cycle 50 for 100 cycles
    rst_n = 1'b0;
    #1;
    chk_dark("rst2");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 50; i++) step(1'b1);
    for (int i = 0; i < 100; i++) step(1'b0);
    for (int i = 0; i < 200; i++) step(1'b1);

    // asynchronous reset during green fade-out
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 200; i++) step(1'b1);
    chk("pre_rst_color", 32'(color), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_dark("async_rst");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) step(1'b1);

    // random run toggling
    for (int i = 0; i < 10000; i++)
      step(logic'($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
